// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU fetch/data memory arbiter: FSM states,
// transaction owner and tie-break policy.
package cpu_mem_arbiter_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    RESP = 4'b0100,
    DLV  = 4'b1000
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int PRIO_RR         = 0;
  localparam int PRIO_FIXED_DATA = 1;

endpackage

// File: rtl/cpu_mem_arbiter_arb_rr2.sv
// Two-requester winner selection (fetch vs data) with last-grant memory
// used for round-robin tie breaking.
module arb_rr2
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int PRIO_DATA = PRIO_RR
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_inst,
  input  logic req_data,
  output logic grant_inst,
  output logic grant_data
);

  owner_t last_grant;
  logic   data_wins;

  // Last grant starts at inst so the first round-robin tie goes to data.
  always_comb begin
    data_wins = 1'b0;
    if (req_data && !req_inst) begin
      data_wins = 1'b1;
    end else if (req_data && req_inst) begin
      data_wins = (PRIO_DATA == PRIO_FIXED_DATA) || (last_grant == OWN_INST);
    end
    grant_data = en && data_wins;
    grant_inst = en && req_inst && !data_wins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= OWN_INST;
    end else if (grant_data) begin
      last_grant <= OWN_DATA;
    end else if (grant_inst) begin
      last_grant <= OWN_INST;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one shared memory
// bus, one outstanding transaction at a time; stores are posted.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int PRIO_DATA = PRIO_RR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_valid,
  input  logic [31:0] inst_req_addr,
  output logic        inst_req_ack,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  input  logic        inst_ack,
  input  logic        mem_req_read,
  input  logic        mem_req_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_req_ack,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  input  logic        rdata_ack,
  output logic        bus_req_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_req_ack,
  input  logic        bus_rdata_valid,
  input  logic [31:0] bus_rdata,
  output logic        bus_rdata_ack,
  output logic [31:0] inst_grant_cnt,
  output logic [31:0] data_grant_cnt
);

  state_t      state, state_nxt;
  owner_t      owner;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata, rdata_q;
  logic [3:0]  lat_wstrb;
  logic        grant_inst, grant_data, arb_en, owner_done;

  // Gating with rst keeps the upstream acks low while reset is held.
  assign arb_en = (state == IDLE) && rst;

  arb_rr2 #(.PRIO_DATA(PRIO_DATA)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .req_inst   (inst_req_valid),
    .req_data   (mem_req_read | mem_req_write),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign owner_done = (owner == OWN_INST) ? inst_ack : rdata_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_inst || grant_data) state_nxt = REQ;
      REQ:     if (bus_req_ack) state_nxt = lat_we ? IDLE : RESP;
      RESP:    if (bus_rdata_valid) state_nxt = DLV;
      DLV:     if (owner_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request with both read and write raised is latched as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_INST;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata_q   <= '0;
    end else begin
      if (grant_data) begin
        owner     <= OWN_DATA;
        lat_we    <= mem_req_write;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
        lat_wstrb <= mem_wstrb;
      end else if (grant_inst) begin
        owner     <= OWN_INST;
        lat_we    <= 1'b0;
        lat_addr  <= inst_req_addr;
        lat_wdata <= '0;
        lat_wstrb <= '0;
      end
      if (state == RESP && bus_rdata_valid) rdata_q <= bus_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_grant_cnt <= '0;
      data_grant_cnt <= '0;
    end else begin
      inst_grant_cnt <= inst_grant_cnt + {31'd0, grant_inst};
      data_grant_cnt <= data_grant_cnt + {31'd0, grant_data};
    end
  end

  assign inst_req_ack  = grant_inst;
  assign mem_req_ack   = grant_data;
  assign bus_req_valid = (state == REQ);
  assign bus_we        = bus_req_valid && lat_we;
  assign bus_addr      = bus_req_valid ? lat_addr  : '0;
  assign bus_wdata     = bus_req_valid ? lat_wdata : '0;
  assign bus_wstrb     = bus_req_valid ? lat_wstrb : '0;
  assign bus_rdata_ack = (state == RESP);
  assign inst_valid    = (state == DLV) && (owner == OWN_INST);
  assign rdata_valid   = (state == DLV) && (owner == OWN_DATA);
  assign inst_data     = inst_valid  ? rdata_q : '0;
  assign rdata         = rdata_valid ? rdata_q : '0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scenario bench for cpu_mem_arbiter: a response scoreboard plus per-scenario
// inline checks on handshakes, bus fields, counters and reset behaviour.
module tb_cpu_mem_arbiter;
  import cpu_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid, inst_req_ack, inst_valid, inst_ack;
  logic [31:0] inst_req_addr, inst_data;
  logic        mem_req_read, mem_req_write, mem_req_ack, rdata_valid, rdata_ack;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_req_valid, bus_we, bus_req_ack, bus_rdata_valid, bus_rdata_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] inst_grant_cnt, data_grant_cnt;

  typedef struct packed {
    owner_t      owner;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_inst_cnt = 0;
  logic [31:0] exp_data_cnt = 0;

  cpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr), .inst_req_ack(inst_req_ack),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ack(inst_ack),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ack(mem_req_ack),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_ack(rdata_ack),
    .bus_req_valid(bus_req_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_req_ack(bus_req_ack), .bus_rdata_valid(bus_rdata_valid),
    .bus_rdata(bus_rdata), .bus_rdata_ack(bus_rdata_ack),
    .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    inst_req_valid = 0; inst_req_addr = 0; inst_ack = 0;
    mem_req_read = 0; mem_req_write = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; rdata_ack = 0;
    bus_req_ack = 0; bus_rdata_valid = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    exp_inst_cnt = 0; exp_data_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({inst_req_ack, inst_valid, mem_req_ack, rdata_valid, bus_req_valid, bus_we, bus_rdata_ack} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {inst_req_ack, inst_valid, mem_req_ack, rdata_valid, bus_req_valid, bus_we, bus_rdata_ack}); end
    checks++; if ({inst_data, rdata, bus_addr, bus_wdata, bus_wstrb} !== 132'b0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0", {inst_data, rdata, bus_addr, bus_wdata, bus_wstrb}); end
    checks++; if ({inst_grant_cnt, data_grant_cnt} !== 64'b0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", {inst_grant_cnt, data_grant_cnt}); end
    inst_req_valid = 1; mem_req_write = 1;
    #1;
    checks++; if ({inst_req_ack, mem_req_ack} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ack: got %b expected 00", {inst_req_ack, mem_req_ack}); end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({inst_req_ack, mem_req_ack, bus_req_valid, bus_rdata_ack, inst_valid, rdata_valid, bus_addr} !== 38'b0) begin
      errors++; $display("[TB] FAIL idle_outputs: got %h expected 0", {inst_req_ack, mem_req_ack, bus_req_valid, bus_rdata_ack, inst_valid, rdata_valid, bus_addr}); end
  endtask

  task automatic test_fetch_alone();
    exp_t e;
    bus_req_ack = 1; bus_rdata_valid = 1; bus_rdata = 32'h0000_0013;
    inst_req_valid = 1; inst_req_addr = 32'h100;
    #1;
    checks++; if ({inst_req_ack, mem_req_ack} !== 2'b10) begin
      errors++; $display("[TB] FAIL fetch_grant: got %b expected 10", {inst_req_ack, mem_req_ack}); end
    exp_q.push_back('{OWN_INST, 32'h0000_0013}); exp_inst_cnt++;
    @(negedge clk);
    inst_req_valid = 0; inst_req_addr = 32'hDEAD_0000;
    checks++; if ({bus_req_valid, bus_we, bus_addr, inst_req_ack} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
      errors++; $display("[TB] FAIL fetch_bus_req: got %h expected %h", {bus_req_valid, bus_we, bus_addr, inst_req_ack}, {1'b1, 1'b0, 32'h100, 1'b0}); end
    @(negedge clk);
    checks++; if ({bus_rdata_ack, bus_req_valid, inst_valid} !== 3'b100) begin
      errors++; $display("[TB] FAIL fetch_resp: got %b expected 100", {bus_rdata_ack, bus_req_valid, inst_valid}); end
    @(negedge clk);
    checks++; if ({inst_valid, rdata_valid} !== 2'b10) begin
      errors++; $display("[TB] FAIL fetch_valid_cycle3: got %b expected 10", {inst_valid, rdata_valid}); end
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL fetch_scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      checks++; if (inst_data !== e.data) begin
        errors++; $display("[TB] FAIL fetch_data: got %h expected %h", inst_data, e.data); end
    end
    checks++; if (inst_grant_cnt !== exp_inst_cnt) begin
      errors++; $display("[TB] FAIL fetch_cnt: got %0d expected %0d", inst_grant_cnt, exp_inst_cnt); end
    inst_ack = 1;
    @(negedge clk);
    inst_ack = 0;
    checks++; if ({inst_valid, bus_rdata_ack, bus_req_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL fetch_done: got %b expected 000", {inst_valid, bus_rdata_ack, bus_req_valid}); end
    idle_inputs();
  endtask

  task automatic test_tie_round_robin();
    owner_t      want[3] = '{OWN_DATA, OWN_INST, OWN_DATA};
    logic [31:0] val;
    logic        got;
    exp_t        e;
    do_reset();
    bus_req_ack = 1; bus_rdata_valid = 1;
    for (int t = 0; t < 3; t++) begin
      inst_req_valid = 1; inst_req_addr = 32'h400 + 32'(t * 4);
      mem_req_read = 1; mem_addr = 32'h800 + 32'(t * 4);
      val = 32'h5A00_0000 | 32'(t); bus_rdata = val;
      #1;
      checks++; if ({mem_req_ack, inst_req_ack} !== ((want[t] == OWN_DATA) ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL tie_grant_%0d: got %b expected %b", t, {mem_req_ack, inst_req_ack}, (want[t] == OWN_DATA) ? 2'b10 : 2'b01); end
      exp_q.push_back('{want[t], val});
      if (want[t] == OWN_DATA) exp_data_cnt++; else exp_inst_cnt++;
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (inst_valid || rdata_valid) got = 1;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      checks++; if (!got) begin
        errors++; $display("[TB] FAIL tie_resp_%0d: got no valid expected response", t);
      end else if ({(rdata_valid ? OWN_DATA : OWN_INST), (rdata_valid ? rdata : inst_data)} !== {e.owner, e.data}) begin
        errors++; $display("[TB] FAIL tie_resp_%0d: got owner %0d data %h expected owner %0d data %h",
                           t, rdata_valid, rdata_valid ? rdata : inst_data, e.owner, e.data);
      end
      inst_ack = 1; rdata_ack = 1;
      @(negedge clk);
      inst_ack = 0; rdata_ack = 0;
    end
    idle_inputs();
    #1;
    checks++; if ({inst_grant_cnt, data_grant_cnt} !== {exp_inst_cnt, exp_data_cnt}) begin
      errors++; $display("[TB] FAIL tie_cnt: got %0d/%0d expected %0d/%0d", inst_grant_cnt, data_grant_cnt, exp_inst_cnt, exp_data_cnt); end
    @(negedge clk);
  endtask

  task automatic test_store_delayed_ack();
    mem_req_write = 1; mem_req_read = 1; mem_addr = 32'h2000; mem_wdata = 32'hAABB_CCDD; mem_wstrb = 4'h4;
    bus_rdata_valid = 1; bus_rdata = 32'h1111_2222;
    #1;
    checks++; if ({mem_req_ack, inst_req_ack} !== 2'b10) begin
      errors++; $display("[TB] FAIL store_grant: got %b expected 10", {mem_req_ack, inst_req_ack}); end
    exp_data_cnt++;
    @(negedge clk);
    mem_req_write = 0; mem_req_read = 0; mem_addr = 32'hDEAD_BEEF; mem_wdata = 0; mem_wstrb = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_req_ack = 1;
      #1;
      checks++; if ({bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb} !== {1'b1, 1'b1, 32'h2000, 32'hAABB_CCDD, 4'h4}) begin
        errors++; $display("[TB] FAIL store_fields_%0d: got %h expected %h", i, {bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb}, {1'b1, 1'b1, 32'h2000, 32'hAABB_CCDD, 4'h4}); end
      @(negedge clk);
    end
    bus_req_ack = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({bus_req_valid, bus_rdata_ack, rdata_valid, inst_valid} !== 4'b0) begin
        errors++; $display("[TB] FAIL store_posted_%0d: got %b expected 0000", i, {bus_req_valid, bus_rdata_ack, rdata_valid, inst_valid}); end
      @(negedge clk);
    end
    mem_req_write = 1; mem_addr = 32'h2004; bus_req_ack = 1;
    #1;
    checks++; if (mem_req_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL store_back_idle: got %b expected 1", mem_req_ack); end
    exp_data_cnt++;
    @(negedge clk);
    mem_req_write = 0;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_load_backpressure();
    exp_t e;
    mem_req_read = 1; mem_addr = 32'h3000;
    bus_req_ack = 1; bus_rdata_valid = 1; bus_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (mem_req_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL load_grant: got %b expected 1", mem_req_ack); end
    exp_q.push_back('{OWN_DATA, 32'hCAFE_F00D}); exp_data_cnt++;
    @(negedge clk);
    mem_req_read = 0;
    @(negedge clk);
    @(negedge clk);
    bus_rdata = 32'h0BAD_0BAD; inst_req_valid = 1; inst_req_addr = 32'h600;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({rdata_valid, rdata} !== {1'b1, e.data}) begin
        errors++; $display("[TB] FAIL load_hold_%0d: got %b/%h expected 1/%h", i, rdata_valid, rdata, e.data); end
      checks++; if ({inst_req_ack, mem_req_ack, inst_valid} !== 3'b000) begin
        errors++; $display("[TB] FAIL load_no_grant_%0d: got %b expected 000", i, {inst_req_ack, mem_req_ack, inst_valid}); end
      @(negedge clk);
    end
    inst_req_valid = 0; rdata_ack = 1;
    @(negedge clk);
    rdata_ack = 0;
    checks++; if ({rdata_valid, inst_grant_cnt, data_grant_cnt} !== {1'b0, exp_inst_cnt, exp_data_cnt}) begin
      errors++; $display("[TB] FAIL load_done: got %b %0d/%0d expected 0 %0d/%0d", rdata_valid, inst_grant_cnt, data_grant_cnt, exp_inst_cnt, exp_data_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_resp();
    mem_req_read = 1; mem_addr = 32'h4000; bus_req_ack = 1;
    #1;
    checks++; if (mem_req_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_grant: got %b expected 1", mem_req_ack); end
    @(negedge clk);
    mem_req_read = 0;
    @(negedge clk);
    checks++; if (bus_rdata_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_in_resp: got %b expected 1", bus_rdata_ack); end
    rst = 1'b0;
    #1;
    checks++; if ({bus_rdata_ack, bus_req_valid, rdata_valid, inst_valid, inst_grant_cnt, data_grant_cnt} !== 68'b0) begin
      errors++; $display("[TB] FAIL rstmid_async: got %h expected 0", {bus_rdata_ack, bus_req_valid, rdata_valid, inst_valid, inst_grant_cnt, data_grant_cnt}); end
    exp_inst_cnt = 0; exp_data_cnt = 0;
    @(negedge clk);
    rst = 1'b1; bus_req_ack = 0; bus_rdata_valid = 1; bus_rdata = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({rdata_valid, inst_valid, bus_rdata_ack, bus_req_valid, rdata} !== 36'b0) begin
        errors++; $display("[TB] FAIL rstmid_late_%0d: got %h expected 0", i, {rdata_valid, inst_valid, bus_rdata_ack, bus_req_valid, rdata}); end
    end
    idle_inputs();
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.data_grant_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.data_grant_cnt;
    exp_data_cnt = 32'hFFFF_FFFF;
    #1;
    checks++; if (data_grant_cnt !== exp_data_cnt) begin
      errors++; $display("[TB] FAIL wrap_preload: got %h expected %h", data_grant_cnt, exp_data_cnt); end
    mem_req_write = 1; mem_addr = 32'h5000; mem_wdata = 32'h1; mem_wstrb = 4'hF; bus_req_ack = 1;
    #1;
    checks++; if (mem_req_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_grant: got %b expected 1", mem_req_ack); end
    exp_data_cnt = exp_data_cnt + 1;
    @(negedge clk);
    mem_req_write = 0;
    checks++; if ({data_grant_cnt, inst_grant_cnt} !== {exp_data_cnt, exp_inst_cnt}) begin
      errors++; $display("[TB] FAIL wrap_cnt: got %h/%h expected %h/%h", data_grant_cnt, inst_grant_cnt, exp_data_cnt, exp_inst_cnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_alone();
    test_tie_round_robin();
    test_store_delayed_ack();
    test_load_backpressure();
    test_reset_mid_resp();
    test_counter_wrap();
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter PRIO_DATA, default 0: 0 = round-robin, 1 = fixed data priority.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port inst_req_valid, input, 1: fetch request.
REQ-005 SHALL have port inst_req_addr, input, 32: fetch address.
REQ-006 SHALL have port inst_req_ack, output, 1: fetch request accepted.
REQ-007 SHALL have ports inst_valid (output, 1), inst_data (output, 32) and inst_ack (input, 1): fetch response handshake.
REQ-008 SHALL have ports mem_req_read (input, 1) and mem_req_write (input, 1): data request type.
REQ-009 SHALL have ports mem_addr (input, 32), mem_wdata (input, 32) and mem_wstrb (input, 4): data request payload.
REQ-010 SHALL have port mem_req_ack, output, 1: data request accepted.
REQ-011 SHALL have ports rdata_valid (output, 1), rdata (output, 32) and rdata_ack (input, 1): load response handshake.
REQ-012 SHALL have ports bus_req_valid (output, 1), bus_we (output, 1), bus_addr (output, 32), bus_wdata (output, 32), bus_wstrb (output, 4) and bus_req_ack (input, 1): shared memory request channel.
REQ-013 SHALL have ports bus_rdata_valid (input, 1), bus_rdata (input, 32) and bus_rdata_ack (output, 1): shared memory read response channel.
REQ-014 SHALL have ports inst_grant_cnt (output, 32) and data_grant_cnt (output, 32): grant counters.

Function
REQ-015 SHALL use a one-hot FSM with states IDLE, REQ, RESP and DLV, and SHALL allow only one outstanding bus transaction.
REQ-016 In IDLE, SHALL select a winner among the pending requests (inst_req_valid; mem_req_read|mem_req_write), pulse that requester's ack combinationally for one cycle, latch addr, we, wdata and wstrb plus an owner bit, and go to REQ.
REQ-017 SHALL break ties by PRIO_DATA: 1 means data wins; 0 means the requester not granted last wins, and the first tie after reset goes to data.
REQ-018 SHALL treat mem_req_read and mem_req_write both high as a write.
REQ-019 In REQ, SHALL hold bus_req_valid=1 and the latched fields stable until bus_req_ack; on ack, a write goes to IDLE (posted, no response) and a read goes to RESP.
REQ-020 In RESP, SHALL hold bus_rdata_ack=1, and on bus_rdata_valid SHALL capture bus_rdata and go to DLV.
REQ-021 In DLV, SHALL hold the owner's valid (inst_valid or rdata_valid) with the registered data until the matching ack, then go to IDLE.
REQ-022 SHALL leave the non-owner's valid 0, and all upstream acks 0, outside IDLE.
REQ-023 Minimum read latency: grant in cycle 0, bus_req_valid in cycle 1, data captured in cycle 2, owner valid in cycle 3.
REQ-024 SHALL keep the FSM in IDLE when no request is pending, with all outputs except the counters at 0.
REQ-025 SHALL ignore a request that drops before it is granted.
REQ-026 SHALL increment the winner's grant counter by 1 at each grant, wrapping at 2^32-1 -> 0.
REQ-027 SHALL make the arbitration decision for the next transaction only in IDLE.
REQ-028 SHALL NOT forward bus_rdata_valid outside RESP.

Reset
REQ-029 While rst=0, SHALL force the FSM to IDLE, every output to 0, both counters to 0, the latched fields to 0, and the last-grant record to inst.
REQ-030 Reset mid-transaction SHALL abandon that transaction; no valid or ack SHALL be produced for it after release.

Structure
REQ-031 The shared package SHALL hold the FSM state encodings, the owner encoding (OWN_INST, OWN_DATA) and the PRIO_DATA encodings.
REQ-032 SHALL place the two-input winner selection and last-grant register in one sub-module, arb_rr2.

Verification
REQ-033 Bench SHALL cover: fetch 0x100 alone, bus returns 0x00000013 -> inst_valid in cycle 3 with inst_data=0x00000013, inst_grant_cnt=1.
REQ-034 Bench SHALL cover: fetch and load pending together after reset with PRIO_DATA=0 -> data granted first, then inst; next tie grants data.
REQ-035 Bench SHALL cover: store addr 0x2000, wdata 0xAABBCCDD, wstrb 0x4, bus_req_ack delayed 3 cycles -> bus fields stable for 4 cycles, no rdata_valid, FSM back in IDLE.
REQ-036 Bench SHALL cover: load with rdata_ack held low 5 cycles -> rdata_valid and rdata stable throughout, no new grant.
REQ-037 Bench SHALL cover: rst low during RESP -> outputs 0 immediately, a late bus_rdata_valid after release ignored.
REQ-038 Bench SHALL cover: data_grant_cnt preloaded to 0xFFFFFFFF through forced stimulus, then one grant -> 0x00000000.
